// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle controller: opcodes, FSM states, ALU functions, decode flag indices.
// Pure declarations; no logic, no latency, no backpressure.
package multicycle_controller_pkg;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b000001;
    localparam logic [5:0] OP_SUB  = 6'b000010;
    localparam logic [5:0] OP_ORI  = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_OR   = 6'b010010;
    localparam logic [5:0] OP_MOVE = 6'b100000;
    localparam logic [5:0] OP_SW   = 6'b100110;
    localparam logic [5:0] OP_LW   = 6'b100111;
    localparam logic [5:0] OP_BEQ  = 6'b110000;
    localparam logic [5:0] OP_HALT = 6'b111111;

    typedef enum logic [2:0] {
        ST_IF  = 3'b000,
        ST_ID  = 3'b001,
        ST_EXE = 3'b010,
        ST_MEM = 3'b011,
        ST_WB  = 3'b100,
        ST_HLT = 3'b111
    } state_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;

    // Bit positions within the one-hot instruction flag vector.
    localparam int IX_ADD  = 0;
    localparam int IX_ADDI = 1;
    localparam int IX_SUB  = 2;
    localparam int IX_ORI  = 3;
    localparam int IX_AND  = 4;
    localparam int IX_OR   = 5;
    localparam int IX_MOVE = 6;
    localparam int IX_SW   = 7;
    localparam int IX_LW   = 8;
    localparam int IX_BEQ  = 9;
    localparam int IX_HALT = 10;
    localparam int N_INSTR = 11;

endpackage

// File: rtl/multicycle_controller_op_decode.sv
// Opcode decode: one-hot instruction flags, valid flag, datapath selects and ALU function.
// Purely combinational (zero latency); no backpressure.
module op_decode
    import multicycle_controller_pkg::*;
(
    input  logic [5:0]         op_i,
    output logic [N_INSTR-1:0] instr_o,
    output logic               valid_o,
    output logic               alu_src_b_o,
    output logic               alu_m2reg_o,
    output logic               ext_sel_o,
    output logic               reg_dst_o,
    output logic [2:0]         alu_op_o
);

    always_comb begin
        instr_o = '0;
        case (op_i)
            OP_ADD:  instr_o[IX_ADD]  = 1'b1;
            OP_ADDI: instr_o[IX_ADDI] = 1'b1;
            OP_SUB:  instr_o[IX_SUB]  = 1'b1;
            OP_ORI:  instr_o[IX_ORI]  = 1'b1;
            OP_AND:  instr_o[IX_AND]  = 1'b1;
            OP_OR:   instr_o[IX_OR]   = 1'b1;
            OP_MOVE: instr_o[IX_MOVE] = 1'b1;
            OP_SW:   instr_o[IX_SW]   = 1'b1;
            OP_LW:   instr_o[IX_LW]   = 1'b1;
            OP_BEQ:  instr_o[IX_BEQ]  = 1'b1;
            OP_HALT: instr_o[IX_HALT] = 1'b1;
            default: ;
        endcase
    end

    assign valid_o = |instr_o;

    assign alu_src_b_o = instr_o[IX_ADDI] | instr_o[IX_ORI] | instr_o[IX_SW] | instr_o[IX_LW];
    assign alu_m2reg_o = instr_o[IX_LW];
    assign ext_sel_o   = instr_o[IX_ADDI] | instr_o[IX_SW] | instr_o[IX_LW] | instr_o[IX_BEQ];
    assign reg_dst_o   = instr_o[IX_ADD] | instr_o[IX_SUB] | instr_o[IX_AND]
                       | instr_o[IX_OR]  | instr_o[IX_MOVE];

    // Undefined opcodes and halt fall through to the add encoding.
    always_comb begin
        alu_op_o = ALU_ADD;
        if (instr_o[IX_SUB] | instr_o[IX_BEQ]) begin
            alu_op_o = ALU_SUB;
        end else if (instr_o[IX_ORI] | instr_o[IX_OR]) begin
            alu_op_o = ALU_OR;
        end else if (instr_o[IX_AND]) begin
            alu_op_o = ALU_AND;
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM (IF/ID/EXE/MEM/WB/HLT): state register, next state, write strobes.
// Instructions take 2..5 cycles; no backpressure, strobes are forced inactive while Reset is high.
module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  logic       CLK,
    input  logic       Reset,
    input  logic [5:0] Op,
    input  logic       zero,
    output logic       PCWre,
    output logic       IRWre,
    output logic       RegWre,
    output logic       RD,
    output logic       WR,
    output logic       ALUSrcB,
    output logic       ALUM2Reg,
    output logic       ExtSel,
    output logic       RegDst,
    output logic       PCSrc,
    output logic [2:0] ALUOp,
    output logic [2:0] State
);

    state_e             state_q;
    state_e             state_d;
    logic [N_INSTR-1:0] instr;
    logic               op_valid;
    logic               is_alu;

    op_decode u_op_decode (
        .op_i        (Op),
        .instr_o     (instr),
        .valid_o     (op_valid),
        .alu_src_b_o (ALUSrcB),
        .alu_m2reg_o (ALUM2Reg),
        .ext_sel_o   (ExtSel),
        .reg_dst_o   (RegDst),
        .alu_op_o    (ALUOp)
    );

    assign is_alu = instr[IX_ADD] | instr[IX_ADDI] | instr[IX_SUB] | instr[IX_ORI]
                  | instr[IX_AND] | instr[IX_OR]   | instr[IX_MOVE];

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IF;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = ST_IF;
        case (state_q)
            ST_IF: state_d = ST_ID;
            ST_ID: begin
                if (instr[IX_HALT]) begin
                    state_d = ST_HLT;
                end else if (op_valid) begin
                    state_d = ST_EXE;
                end else begin
                    state_d = ST_IF;
                end
            end
            ST_EXE: begin
                if (instr[IX_BEQ]) begin
                    state_d = ST_IF;
                end else if (instr[IX_SW] | instr[IX_LW]) begin
                    state_d = ST_MEM;
                end else if (is_alu) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_IF;
                end
            end
            ST_MEM: state_d = instr[IX_LW] ? ST_WB : ST_IF;
            ST_WB:  state_d = ST_IF;
            ST_HLT: state_d = ST_HLT;
            default: state_d = ST_IF;
        endcase
    end

    // Gating on Reset keeps strobes quiet for the whole assertion, including the IF state it forces.
    always_comb begin
        PCWre  = 1'b0;
        IRWre  = 1'b0;
        RegWre = 1'b0;
        RD     = 1'b1;
        WR     = 1'b1;
        PCSrc  = 1'b0;
        if (!Reset) begin
            case (state_q)
                ST_IF: IRWre = 1'b1;
                ST_ID: PCWre = ~op_valid;
                ST_EXE: begin
                    if (instr[IX_BEQ]) begin
                        PCWre = 1'b1;
                        PCSrc = zero;
                    end
                end
                ST_MEM: begin
                    if (instr[IX_SW]) begin
                        PCWre = 1'b1;
                        WR    = 1'b0;
                    end else if (instr[IX_LW]) begin
                        RD = 1'b0;
                    end
                end
                ST_WB: begin
                    PCWre  = 1'b1;
                    RegWre = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign State = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class through its states.
module tb_multicycle_controller;

    localparam logic [2:0] S_IF  = 3'b000;
    localparam logic [2:0] S_ID  = 3'b001;
    localparam logic [2:0] S_EXE = 3'b010;
    localparam logic [2:0] S_MEM = 3'b011;
    localparam logic [2:0] S_WB  = 3'b100;
    localparam logic [2:0] S_HLT = 3'b111;

    logic       CLK = 1'b0;
    logic       Reset;
    logic [5:0] Op;
    logic       zero;
    logic       PCWre, IRWre, RegWre, RD, WR;
    logic       ALUSrcB, ALUM2Reg, ExtSel, RegDst, PCSrc;
    logic [2:0] ALUOp;
    logic [2:0] State;

    int n_checks = 0;
    int n_pass   = 0;

    multicycle_controller dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .Op       (Op),
        .zero     (zero),
        .PCWre    (PCWre),
        .IRWre    (IRWre),
        .RegWre   (RegWre),
        .RD       (RD),
        .WR       (WR),
        .ALUSrcB  (ALUSrcB),
        .ALUM2Reg (ALUM2Reg),
        .ExtSel   (ExtSel),
        .RegDst   (RegDst),
        .PCSrc    (PCSrc),
        .ALUOp    (ALUOp),
        .State    (State)
    );

    always #5 CLK = ~CLK;

    // {State, PCWre, IRWre, RegWre, RD, WR, PCSrc}
    logic [8:0] ctl;
    // {ALUSrcB, ALUM2Reg, ExtSel, RegDst, ALUOp}
    logic [6:0] sel;
    assign ctl = {State, PCWre, IRWre, RegWre, RD, WR, PCSrc};
    assign sel = {ALUSrcB, ALUM2Reg, ExtSel, RegDst, ALUOp};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] ev(input logic [2:0] st, input logic pc, input logic ir,
                                      input logic rw, input logic rd, input logic wr,
                                      input logic ps);
        return {st, pc, ir, rw, rd, wr, ps};
    endfunction

    task automatic expect_ctl(input string tag, input logic [8:0] e);
        check(tag, 32'(ctl), 32'(e));
    endtask

    task automatic expect_sel(input string tag, input logic [6:0] e);
        check(tag, 32'(sel), 32'(e));
    endtask

    task automatic step(input string tag, input logic [8:0] e);
        @(posedge CLK);
        #2;
        expect_ctl(tag, e);
    endtask

    logic [5:0] tbl_op  [10];
    logic [6:0] tbl_sel [10];

    initial begin
        tbl_op[0] = 6'b000000; tbl_sel[0] = 7'b0001000;  // add
        tbl_op[1] = 6'b000001; tbl_sel[1] = 7'b1010000;  // addi
        tbl_op[2] = 6'b000010; tbl_sel[2] = 7'b0001001;  // sub
        tbl_op[3] = 6'b010000; tbl_sel[3] = 7'b1000011;  // ori
        tbl_op[4] = 6'b010001; tbl_sel[4] = 7'b0001100;  // and
        tbl_op[5] = 6'b010010; tbl_sel[5] = 7'b0001011;  // or
        tbl_op[6] = 6'b100000; tbl_sel[6] = 7'b0001000;  // move
        tbl_op[7] = 6'b100110; tbl_sel[7] = 7'b1010000;  // sw
        tbl_op[8] = 6'b100111; tbl_sel[8] = 7'b1110000;  // lw
        tbl_op[9] = 6'b110000; tbl_sel[9] = 7'b0010001;  // beq

        Reset = 1'b1;
        Op    = 6'b000000;
        zero  = 1'b0;
        @(posedge CLK);
        #2;
        expect_ctl("reset held", ev(S_IF, 0, 0, 0, 1, 1, 0));
        @(posedge CLK);
        #2;
        expect_ctl("reset held 2", ev(S_IF, 0, 0, 0, 1, 1, 0));

        // add
        @(negedge CLK);
        Reset = 1'b0;
        Op    = 6'b000000;
        #1;
        expect_ctl("add IF", ev(S_IF, 0, 1, 0, 1, 1, 0));
        step("add ID", ev(S_ID, 0, 0, 0, 1, 1, 0));
        expect_sel("add sel ID", 7'b0001000);
        step("add EXE", ev(S_EXE, 0, 0, 0, 1, 1, 0));
        step("add WB", ev(S_WB, 1, 0, 1, 1, 1, 0));
        expect_sel("add sel WB", 7'b0001000);
        step("add end IF", ev(S_IF, 0, 1, 0, 1, 1, 0));

        // lw
        Op = 6'b100111;
        step("lw ID", ev(S_ID, 0, 0, 0, 1, 1, 0));
        step("lw EXE", ev(S_EXE, 0, 0, 0, 1, 1, 0));
        step("lw MEM", ev(S_MEM, 0, 0, 0, 0, 1, 0));
        expect_sel("lw sel MEM", 7'b1110000);
        step("lw WB", ev(S_WB, 1, 0, 1, 1, 1, 0));
        step("lw end IF", ev(S_IF, 0, 1, 0, 1, 1, 0));

        // beq taken
        Op   = 6'b110000;
        zero = 1'b1;
        step("beq1 ID", ev(S_ID, 0, 0, 0, 1, 1, 0));
        step("beq1 EXE", ev(S_EXE, 1, 0, 0, 1, 1, 1));
        expect_sel("beq sel EXE", 7'b0010001);
        step("beq1 end IF", ev(S_IF, 0, 1, 0, 1, 1, 0));

        // beq not taken
        zero = 1'b0;
        step("beq0 ID", ev(S_ID, 0, 0, 0, 1, 1, 0));
        step("beq0 EXE", ev(S_EXE, 1, 0, 0, 1, 1, 0));
        step("beq0 end IF", ev(S_IF, 0, 1, 0, 1, 1, 0));

        // undefined opcode
        Op = 6'b000111;
        step("undef ID", ev(S_ID, 1, 0, 0, 1, 1, 0));
        expect_sel("undef sel", 7'b0000000);
        step("undef end IF", ev(S_IF, 0, 1, 0, 1, 1, 0));

        // sw, with Op wobbling during IF
        Op = 6'b111111;
        #1;
        Op = 6'b100110;
        step("sw ID", ev(S_ID, 0, 0, 0, 1, 1, 0));
        step("sw EXE", ev(S_EXE, 0, 0, 0, 1, 1, 0));
        step("sw MEM", ev(S_MEM, 1, 0, 0, 1, 0, 0));
        expect_sel("sw sel MEM", 7'b1010000);
        step("sw end IF", ev(S_IF, 0, 1, 0, 1, 1, 0));

        // sw aborted by reset in MEM
        step("swr ID", ev(S_ID, 0, 0, 0, 1, 1, 0));
        step("swr EXE", ev(S_EXE, 0, 0, 0, 1, 1, 0));
        step("swr MEM", ev(S_MEM, 1, 0, 0, 1, 0, 0));
        #1;
        Reset = 1'b1;
        #1;
        expect_ctl("swr reset now", ev(S_IF, 0, 0, 0, 1, 1, 0));
        step("swr reset held", ev(S_IF, 0, 0, 0, 1, 1, 0));
        @(negedge CLK);
        Reset = 1'b0;
        Op    = 6'b111111;
        #1;
        expect_ctl("post reset IF", ev(S_IF, 0, 1, 0, 1, 1, 0));

        // halt
        step("halt ID", ev(S_ID, 0, 0, 0, 1, 1, 0));
        step("halt HLT", ev(S_HLT, 0, 0, 0, 1, 1, 0));
        for (int i = 0; i < 20; i++) begin
            if (i == 10) Op = 6'b000000;
            step($sformatf("halt hold %0d", i), ev(S_HLT, 0, 0, 0, 1, 1, 0));
        end

        // datapath selects are purely opcode-driven
        for (int i = 0; i < 10; i++) begin
            Op = tbl_op[i];
            #1;
            expect_sel($sformatf("sel op %b", tbl_op[i]), tbl_sel[i]);
            expect_ctl($sformatf("hlt ctl op %b", tbl_op[i]), ev(S_HLT, 0, 0, 0, 1, 1, 0));
        end

        Reset = 1'b1;
        #1;
        expect_ctl("final reset", ev(S_IF, 0, 0, 0, 1, 1, 0));
        @(posedge CLK);
        #2;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
